// File: rtl/rdsel_align.sv
`default_nettype none
// ============================================================================
//  Module   : rdsel_align
//  Purpose  : Load-data aligner/extender for the core load path. Selects a
//             byte/half/word/dword from a memory read word at a byte offset,
//             right-aligns it and zero- or sign-extends it to DATA_WIDTH.
//             Accesses that cross a word boundary are either merged over two
//             input beats (MISALIGN_EN=1) or reported as errors.
//  Ports    : clk, srst                  - clock, synchronous active-high reset
//             in_valid/in_ready          - input beat handshake
//             in_data/in_off/in_size/
//             in_signed                  - read word and access attributes
//             out_valid/out_ready        - result handshake
//             out_data/out_err           - aligned result, error flag
//  Revision : 1.0 - initial release
// ============================================================================
module rdsel_align #(
    parameter int DATA_WIDTH  = 32,
    parameter int MISALIGN_EN = 1,
    localparam int OFFW       = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [OFFW-1:0]       in_off,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    localparam int         NB    = DATA_WIDTH / 8;
    // Wide enough for off + nbytes of any legal access (max 2*NB-1).
    localparam int         NBW   = OFFW + 2;
    localparam logic [1:0] MAXSZ = 2'(OFFW);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT2 = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [OFFW-1:0]       off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_err_q, out_err_d;

    logic                    accept;
    logic [OFFW-1:0]         eff_off;
    logic [1:0]              eff_size;
    logic                    eff_sgn;
    logic [2*DATA_WIDTH-1:0] pair;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [NBW-1:0]          nbytes;
    logic                    size_bad;
    logic                    crosses;
    logic                    sign_bit;
    logic                    fill;
    logic [DATA_WIDTH-1:0]   aligned;

    // The output slot is free when empty or being drained this cycle; this
    // depends only on registered state and out_ready.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Shared datapath: in IDLE the access attributes come straight from the
    // input; in WAIT2 they come from the first beat and the new beat forms
    // the upper half of the two-word window.
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == ST_WAIT2) begin
            eff_off  = off_q;
            eff_size = size_q;
            eff_sgn  = sgn_q;
            pair     = {in_data, hold_q};
        end else begin
            eff_off  = in_off;
            eff_size = in_size;
            eff_sgn  = in_signed;
            pair     = {{DATA_WIDTH{1'b0}}, in_data};
        end
    end

    assign size_bad = (state_q == ST_IDLE) && (in_size > MAXSZ);
    assign nbytes   = NBW'(1) << eff_size;
    assign crosses  = ({2'b00, eff_off} + nbytes) > NBW'(NB);
    assign sel_word = DATA_WIDTH'(pair >> {eff_off, 3'b000});

    always_comb begin
        sign_bit = 1'b0;
        for (int s = 0; s <= OFFW; s++) begin
            if (eff_size == 2'(s)) begin
                sign_bit = sel_word[8*(1<<s)-1];
            end
        end
        fill    = eff_sgn & sign_bit;
        aligned = '0;
        for (int k = 0; k < NB; k++) begin
            if (NBW'(k) < nbytes) begin
                aligned[8*k +: 8] = sel_word[8*k +: 8];
            end else begin
                aligned[8*k +: 8] = {8{fill}};
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!size_bad && crosses && (MISALIGN_EN != 0)) begin
                        state_d = ST_WAIT2;
                    end
                end
                ST_WAIT2: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / hold-register next values
    // ------------------------------------------------------------------
    always_comb begin
        hold_d      = hold_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        // A held result survives only while downstream stalls.
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        if (accept) begin
            if (state_q == ST_WAIT2) begin
                out_valid_d = 1'b1;
                out_data_d  = aligned;
                out_err_d   = 1'b0;
            end else if (size_bad) begin
                out_valid_d = 1'b1;
                out_data_d  = '0;
                out_err_d   = 1'b1;
            end else if (!crosses) begin
                out_valid_d = 1'b1;
                out_data_d  = aligned;
                out_err_d   = 1'b0;
            end else if (MISALIGN_EN != 0) begin
                // First half of a crossing access: park it, no result yet.
                hold_d = in_data;
                off_d  = in_off;
                size_d = in_size;
                sgn_d  = in_signed;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = '0;
                out_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hold_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire
